// File: rtl/m_demux_1in2out_buf_pkg.sv
// Shared defaults and the clog2 helper for the 1-in/2-out buffered demux.
package m_demux_1in2out_buf_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 2;
    localparam int NUM_OUTS       = 2;

    function automatic int f_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/m_demux_1in2out_buf_fifo.sv
// Flit FIFO: registered storage, head read straight from memory, forced to 0 when empty.
module m_flit_fifo
    import m_demux_1in2out_buf_pkg::*;
#(
    parameter int P_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int P_FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [P_DATA_WIDTH-1:0]              data_in,
    output logic [P_DATA_WIDTH-1:0]              data_out,
    output logic                                 empty,
    output logic                                 full,
    output logic [f_clog2(P_FIFO_DEPTH):0]       count
);

    localparam int AW = f_clog2(P_FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [P_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    push_ok, pop_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(P_FIFO_DEPTH));
    assign count    = count_q;
    // Empty covers reset too, so the head reads 0 whenever nothing is stored.
    assign data_out = empty ? '0 : mem[rd_ptr_q];

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= data_in;
    end

endmodule

// File: rtl/m_demux_1in2out_buf.sv
// One input stream steered by select into one of two flit FIFOs.
module m_demux_1in2out_buf
    import m_demux_1in2out_buf_pkg::*;
#(
    parameter int P_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int P_FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           select,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [P_DATA_WIDTH-1:0]        data_in,
    output logic                           out_valid_0,
    output logic                           out_valid_1,
    input  logic                           out_ready_0,
    input  logic                           out_ready_1,
    output logic [P_DATA_WIDTH-1:0]        data_out_0,
    output logic [P_DATA_WIDTH-1:0]        data_out_1,
    output logic [f_clog2(P_FIFO_DEPTH):0] count_0,
    output logic [f_clog2(P_FIFO_DEPTH):0] count_1
);

    localparam int CW = f_clog2(P_FIFO_DEPTH) + 1;

    logic                                    push;
    logic [NUM_OUTS-1:0]                     push_v, pop_v, empty_v, full_v, ready_v;
    logic [NUM_OUTS-1:0][P_DATA_WIDTH-1:0]   dout_v;
    logic [NUM_OUTS-1:0][CW-1:0]             cnt_v;

    // Full is checked before any same-cycle pop: no bypass into a full FIFO.
    assign in_ready = select ? ~full_v[1] : ~full_v[0];
    assign push     = in_valid & in_ready;
    assign push_v   = {push & select, push & ~select};
    assign ready_v  = {out_ready_1, out_ready_0};
    assign pop_v    = ready_v & ~empty_v;

    for (genvar g = 0; g < NUM_OUTS; g++) begin : g_fifo
        m_flit_fifo #(
            .P_DATA_WIDTH (P_DATA_WIDTH),
            .P_FIFO_DEPTH (P_FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset_n  (reset_n),
            .push     (push_v[g]),
            .pop      (pop_v[g]),
            .data_in  (data_in),
            .data_out (dout_v[g]),
            .empty    (empty_v[g]),
            .full     (full_v[g]),
            .count    (cnt_v[g])
        );
    end

    assign out_valid_0 = ~empty_v[0];
    assign out_valid_1 = ~empty_v[1];
    assign data_out_0  = dout_v[0];
    assign data_out_1  = dout_v[1];
    assign count_0     = cnt_v[0];
    assign count_1     = cnt_v[1];

endmodule

// File: tb/tb_m_demux_1in2out_buf.sv
// Scoreboard bench: expected flits queued per output on accepted pushes, compared on pops.
module tb_m_demux_1in2out_buf;

    localparam int DW = 8;
    localparam int D  = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          select, in_valid, in_ready;
    logic [DW-1:0] data_in;
    logic          out_valid_0, out_valid_1, out_ready_0, out_ready_1;
    logic [DW-1:0] data_out_0, data_out_1;
    logic [CW-1:0] count_0, count_1;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] sb0 [$];
    logic [DW-1:0] sb1 [$];

    always #5 clk = ~clk;

    m_demux_1in2out_buf #(.P_DATA_WIDTH(DW), .P_FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .select      (select),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .out_valid_0 (out_valid_0),
        .out_valid_1 (out_valid_1),
        .out_ready_0 (out_ready_0),
        .out_ready_1 (out_ready_1),
        .data_out_0  (data_out_0),
        .data_out_1  (data_out_1),
        .count_0     (count_0),
        .count_1     (count_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check outputs against the model, commit at posedge.
    task automatic step(input logic sel, input logic iv, input logic [DW-1:0] d,
                        input logic r0, input logic r1);
        logic exp_rdy, do_push, do_pop0, do_pop1;
        @(negedge clk);
        select = sel; in_valid = iv; data_in = d; out_ready_0 = r0; out_ready_1 = r1;
        #1;
        exp_rdy = sel ? (sb1.size() < D) : (sb0.size() < D);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid_0", 32'(out_valid_0), 32'(sb0.size() != 0));
        chk("out_valid_1", 32'(out_valid_1), 32'(sb1.size() != 0));
        chk("count_0", 32'(count_0), 32'(sb0.size()));
        chk("count_1", 32'(count_1), 32'(sb1.size()));
        if (sb0.size() != 0) chk("data_out_0", 32'(data_out_0), 32'(sb0[0]));
        if (sb1.size() != 0) chk("data_out_1", 32'(data_out_1), 32'(sb1[0]));
        do_push = iv && exp_rdy;
        do_pop0 = r0 && (sb0.size() != 0);
        do_pop1 = r1 && (sb1.size() != 0);
        @(posedge clk);
        if (do_pop0) void'(sb0.pop_front());
        if (do_pop1) void'(sb1.pop_front());
        if (do_push) begin
            if (sel) sb1.push_back(d);
            else     sb0.push_back(d);
        end
        #1;
    endtask

    initial begin
        reset_n = 1'b0; select = 1'b0; in_valid = 1'b0; data_in = '0;
        out_ready_0 = 1'b0; out_ready_1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_0", 32'(out_valid_0), 32'd0);
        chk("rst_valid_1", 32'(out_valid_1), 32'd0);
        chk("rst_count_0", 32'(count_0), 32'd0);
        chk("rst_count_1", 32'(count_1), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_data_0", 32'(data_out_0), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single push, one-cycle latency
        step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("a5_valid_0", 32'(out_valid_0), 32'd1);
        chk("a5_data_0", 32'(data_out_0), 32'hA5);
        chk("a5_valid_1", 32'(out_valid_1), 32'd0);
        chk("a5_count_0", 32'(count_0), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Fill output 1; in_ready follows select
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        chk("fill_count_1", 32'(count_1), 32'd2);
        chk("fill_rdy_sel1", 32'(in_ready), 32'd0);
        select = 1'b0;
        #1;
        chk("fill_rdy_sel0", 32'(in_ready), 32'd1);

        // Full + pop same cycle: no push that cycle, accepted next cycle
        step(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
        chk("nobypass_count_1", 32'(count_1), 32'd1);
        chk("nobypass_data_1", 32'(data_out_1), 32'h22);
        step(1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        chk("retry_count_1", 32'(count_1), 32'd2);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous push and pop on a one-entry FIFO
        step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
        chk("pp_count_0", 32'(count_0), 32'd1);
        chk("pp_data_0", 32'(data_out_0), 32'h33);

        // Mid-cycle reset with both FIFOs non-empty
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready_0 = 1'b0; out_ready_1 = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_valid_0", 32'(out_valid_0), 32'd0);
        chk("mrst_valid_1", 32'(out_valid_1), 32'd0);
        chk("mrst_count_0", 32'(count_0), 32'd0);
        chk("mrst_count_1", 32'(count_1), 32'd0);
        chk("mrst_data_1", 32'(data_out_1), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        sb0.delete();
        sb1.delete();
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 1'b1, 8'h7E, 1'b0, 1'b0);
        chk("post_rst_data_0", 32'(data_out_0), 32'h7E);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        // Drain and confirm nothing left behind
        for (int i = 0; i < 2 * D + 2; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("drain_count_0", 32'(count_0), 32'd0);
        chk("drain_count_1", 32'(count_1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
